// File: rtl/ff_pkg.sv
// rtl/ff_pkg.sv - mode encodings and T-excitation helper for universal_ff_reg
package ff_pkg;

  localparam logic [2:0] MODE_D      = 3'd0;
  localparam logic [2:0] MODE_T      = 3'd1;
  localparam logic [2:0] MODE_JK     = 3'd2;
  localparam logic [2:0] MODE_SR     = 3'd3;
  localparam logic [2:0] MODE_CNT_UP = 3'd4;
  localparam logic [2:0] MODE_CNT_DN = 3'd5;

  // Toggle that turns q into d; applied per bit.
  function automatic logic t_from_d(input logic q, input logic d);
    return q ^ d;
  endfunction

endpackage

// File: rtl/ff_next_bit.sv
// rtl/ff_next_bit.sv - single-bit next-state slice for D/T/JK/SR and counter modes
module ff_next_bit
  import ff_pkg::*;
(
  input  logic [2:0] mode_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       q_i,
  input  logic       carry_i,
  output logic       q_next_o,
  output logic       toggle_o,
  output logic       carry_o,
  output logic       illegal_o
);

  always_comb begin
    q_next_o  = q_i;
    carry_o   = 1'b0;
    illegal_o = 1'b0;
    case (mode_i)
      MODE_D:  q_next_o = a_i;
      MODE_T:  q_next_o = q_i ^ a_i;
      MODE_JK: begin
        case ({a_i, b_i})
          2'b01:   q_next_o = 1'b0;
          2'b10:   q_next_o = 1'b1;
          2'b11:   q_next_o = ~q_i;
          default: q_next_o = q_i;
        endcase
      end
      MODE_SR: begin
        case ({a_i, b_i})
          2'b01:   q_next_o = 1'b0;
          2'b10:   q_next_o = 1'b1;
          2'b11:   illegal_o = 1'b1;
          default: q_next_o = q_i;
        endcase
      end
      // Counter toggles ripple as an AND chain of (inverted for down) lower bits.
      MODE_CNT_UP: begin
        q_next_o = q_i ^ carry_i;
        carry_o  = carry_i & q_i;
      end
      MODE_CNT_DN: begin
        q_next_o = q_i ^ carry_i;
        carry_o  = carry_i & ~q_i;
      end
      default: q_next_o = q_i;
    endcase
  end

  assign toggle_o = t_from_d(q_i, q_next_o);

endmodule

// File: rtl/universal_ff_reg.sv
// rtl/universal_ff_reg.sv - mode-selectable D/T/JK/SR/counter register with T-excitation output
module universal_ff_reg
  import ff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_exc,
  output logic             tc,
  output logic             sr_err
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] t_exc_q, t_exc_d;
  logic             sr_err_q, sr_err_d;
  logic [WIDTH-1:0] next_bits, toggle_bits, illegal_bits;
  logic [WIDTH:0]   carry;

  assign carry[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ff_next_bit u_next_bit (
      .mode_i    (mode),
      .a_i       (a[gi]),
      .b_i       (b[gi]),
      .q_i       (q_q[gi]),
      .carry_i   (carry[gi]),
      .q_next_o  (next_bits[gi]),
      .toggle_o  (toggle_bits[gi]),
      .carry_o   (carry[gi+1]),
      .illegal_o (illegal_bits[gi])
    );
  end

  always_comb begin
    q_d      = en ? next_bits : q_q;
    t_exc_d  = en ? toggle_bits : '0;
    sr_err_d = (en & (|illegal_bits)) | (sr_err_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= '0;
      t_exc_q  <= '0;
      sr_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      t_exc_q  <= t_exc_d;
      sr_err_q <= sr_err_d;
    end
  end

  // The final carry is nonzero only in a counter mode whose next edge wraps.
  assign tc     = en & carry[WIDTH];
  assign q      = q_q;
  assign t_exc  = t_exc_q;
  assign sr_err = sr_err_q;

endmodule

// File: tb/tb_universal_ff_reg.sv
// tb/tb_universal_ff_reg.sv - directed scoreboard bench for universal_ff_reg
module tb_universal_ff_reg;
  import ff_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr_err;
  logic [2:0] mode;
  logic [3:0] a, b;
  logic [3:0] q, t_exc;
  logic       tc, sr_err;

  universal_ff_reg #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .a       (a),
    .b       (b),
    .clr_err (clr_err),
    .q       (q),
    .t_exc   (t_exc),
    .tc      (tc),
    .sr_err  (sr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] t;
    logic       e;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] q_model  = 4'b0000;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] tvec(input logic [3:0] o, input logic [3:0] n);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = t_from_d(o[i], n[i]);
    return r;
  endfunction

  task automatic drive(input logic e, input logic [2:0] m, input logic [3:0] av,
                       input logic [3:0] bv, input logic c);
    en = e; mode = m; a = av; b = bv; clr_err = c;
  endtask

  task automatic push(input logic [3:0] nq, input logic ne, input string tag);
    exp_t x;
    x.q = nq; x.t = tvec(q_model, nq); x.e = ne; x.tag = tag;
    q_model = nq;
    sb.push_back(x);
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", sb.size());
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk({x.tag, "_q"}, q, x.q);
      chk({x.tag, "_t_exc"}, t_exc, x.t);
      chk({x.tag, "_sr_err"}, {3'b000, sr_err}, {3'b000, x.e});
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, MODE_D, 4'b0000, 4'b0000, 1'b0);
    #12;
    chk("reset_q", q, 4'b0000);
    chk("reset_t_exc", t_exc, 4'b0000);
    chk("reset_sr_err", {3'b000, sr_err}, 4'b0000);
    rst = 1'b1;
    push(4'b0000, 1'b0, "release_hold"); tick();

    // Load, then make t_exc and sr_err nonzero before an asynchronous reset.
    drive(1'b1, MODE_D, 4'b1010, 4'b0000, 1'b0); push(4'b1010, 1'b0, "d_load"); tick();
    drive(1'b1, MODE_SR, 4'b0101, 4'b0001, 1'b0); push(4'b1110, 1'b1, "sr_pre"); tick();
    rst = 1'b0;
    #1;
    chk("async_rst_q", q, 4'b0000);
    chk("async_rst_t_exc", t_exc, 4'b0000);
    chk("async_rst_sr_err", {3'b000, sr_err}, 4'b0000);
    q_model = 4'b0000;
    drive(1'b0, MODE_D, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    push(4'b0000, 1'b0, "post_rst_hold"); tick();

    drive(1'b1, MODE_D, 4'b0110, 4'b0000, 1'b0); push(4'b0110, 1'b0, "d_0110"); tick();
    drive(1'b1, MODE_T, 4'b0011, 4'b0000, 1'b0); push(4'b0101, 1'b0, "t_0011"); tick();
    drive(1'b0, MODE_T, 4'b0011, 4'b0000, 1'b0); push(4'b0101, 1'b0, "en_off"); tick();

    drive(1'b1, MODE_D, 4'b0011, 4'b0000, 1'b0); push(4'b0011, 1'b0, "jk_load"); tick();
    drive(1'b1, MODE_JK, 4'b0101, 4'b0011, 1'b0); push(4'b0100, 1'b0, "jk_all"); tick();

    drive(1'b1, MODE_D, 4'b1100, 4'b0000, 1'b0); push(4'b1100, 1'b0, "sr_load"); tick();
    drive(1'b1, MODE_SR, 4'b1010, 4'b0110, 1'b0); push(4'b1000, 1'b1, "sr_illegal"); tick();
    drive(1'b0, MODE_SR, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      push(4'b1000, 1'b1, "sr_sticky"); tick();
    end
    drive(1'b0, MODE_SR, 4'b0000, 4'b0000, 1'b1); push(4'b1000, 1'b0, "sr_clear"); tick();
    drive(1'b1, MODE_SR, 4'b0001, 4'b0001, 1'b1); push(4'b1000, 1'b1, "sr_set_wins"); tick();
    drive(1'b0, MODE_SR, 4'b0000, 4'b0000, 1'b1); push(4'b1000, 1'b0, "sr_clear2"); tick();

    drive(1'b1, MODE_D, 4'b1110, 4'b0000, 1'b0); push(4'b1110, 1'b0, "cnt_load"); tick();
    drive(1'b1, MODE_CNT_UP, 4'b0000, 4'b0000, 1'b0);
    #1; chk("tc_up_1110", {3'b000, tc}, 4'b0000);
    push(4'b1111, 1'b0, "up_1111"); tick();
    chk("tc_up_1111", {3'b000, tc}, 4'b0001);
    push(4'b0000, 1'b0, "up_wrap"); tick();
    drive(1'b0, MODE_CNT_DN, 4'b0000, 4'b0000, 1'b0);
    #1; chk("tc_dn_en0", {3'b000, tc}, 4'b0000);
    drive(1'b1, MODE_CNT_DN, 4'b0000, 4'b0000, 1'b0);
    #1; chk("tc_dn_0000", {3'b000, tc}, 4'b0001);
    push(4'b1111, 1'b0, "dn_wrap"); tick();
    chk("tc_dn_1111", {3'b000, tc}, 4'b0000);

    drive(1'b1, 3'd6, 4'b1111, 4'b1111, 1'b0);
    #1; chk("tc_mode6", {3'b000, tc}, 4'b0000);
    push(4'b1111, 1'b0, "mode6"); tick();
    drive(1'b1, 3'd7, 4'b0000, 4'b1111, 1'b0); push(4'b1111, 1'b0, "mode7"); tick();

    drive(1'b1, MODE_D, 4'b0000, 4'b0000, 1'b0); push(4'b0000, 1'b0, "cnt_zero"); tick();
    drive(1'b1, MODE_CNT_UP, 4'b0000, 4'b0000, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      push(4'(i), 1'b0, "up_count"); tick();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_q", q, 4'b0000);
    chk("mid_rst_t_exc", t_exc, 4'b0000);
    q_model = 4'b0000;
    rst = 1'b1;
    push(4'b0001, 1'b0, "resume_0001"); tick();
    push(4'b0010, 1'b0, "resume_0010"); tick();

    chk("scoreboard_drained", 4'(sb.size()), 4'b0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/universal_ff_reg.md
Name: universal_ff_reg

Overview:
- WIDTH-bit register whose storage is plain D flip-flops.
- Each cycle, a mode select makes the register behave as a D, T, JK or SR flip-flop bank, or as a synchronous up/down counter built from T-excitation logic.
- Also reports the T-excitation vector of each transition, i.e. the toggle pattern that reproduces it.
- Lab building block for the flip-flop conversion exercises; pairs with the existing D-from-T conversion work.

Parameters:
- WIDTH, 4, number of register bits (1..16).

Ports:
- clk     input   1      rising-edge clock
- rst     input   1      asynchronous reset, active-low
- en      input   1      update enable; 0 = hold all state
- mode    input   3      0=D, 1=T, 2=JK, 3=SR, 4=CNT_UP, 5=CNT_DN, 6/7=reserved (hold)
- a       input   WIDTH  D / T / J / S per bit
- b       input   WIDTH  K / R per bit; ignored in other modes
- clr_err input   1      synchronous clear of sr_err
- q       output  WIDTH  register state
- t_exc   output  WIDTH  registered T-excitation of the last clock edge: q_new XOR q_old
- tc      output  1      combinational terminal count
- sr_err  output  1      sticky flag: an SR bit saw S=R=1

Behaviour:
- Reset: rst low forces q=0, t_exc=0 and sr_err=0 immediately, with no clock needed. Release is taken at the next rising edge. If rst is asserted mid-count, the count is lost and restarts from 0.
- Storage is D flops only. Next-state logic per bit i, applied at the rising clk edge when en=1:
  - D: q[i] <= a[i]
  - T: q[i] <= q[i] ^ a[i]
  - JK: J=0,K=0 hold; 0,1 clear; 1,0 set; 1,1 toggle
  - SR: S=0,R=0 hold; 0,1 clear; 1,0 set; 1,1 is illegal, the bit holds and sr_err sets
  - CNT_UP: T[0]=1; T[i] = AND of q[i-1:0]; q <= q ^ T. This is modulo 2^WIDTH, so all-ones wraps to 0.
  - CNT_DN: T[0]=1; T[i] = AND of ~q[i-1:0]. Zero wraps to all-ones.
  - Modes 6/7: q holds and no flag is raised.
- en=0: q holds in every mode. t_exc updates to 0 and sr_err holds.
- t_exc updates at every rising edge to (next q) XOR (current q), so it equals the T input that would produce the same transition. Latency is 1 cycle, aligned with the new q. A hold cycle yields t_exc=0.
- tc is combinational:
  - en=1 and mode=CNT_UP and q all-ones, or
  - en=1 and mode=CNT_DN and q==0.
  - It is 0 in all other cases and signals that the next edge wraps.
- sr_err sets when en=1, mode=SR and (a & b) is non-zero at an edge. It clears only on clr_err=1 or reset. If set and clear occur in the same cycle, set wins.
- A mode change takes effect at the next edge with no pipeline, so mixed-mode sequences are legal cycle by cycle.

Decomposition:
- Shared package ff_pkg holds:
  - the mode encodings MODE_D, MODE_T, MODE_JK, MODE_SR, MODE_CNT_UP, MODE_CNT_DN as 3-bit constants
  - a function t_from_d(q, d) returning q ^ d, also used by the bench
- One natural sub-module, ff_next_bit: a single-bit next-state combinational slice taking mode, a, b, q and a carry-in toggle. It returns the next value, the toggle and the carry-out toggle, plus an illegal flag. The top instantiates it WIDTH times in a chain for the counter carry, and holds the D flops, the t_exc register and sr_err.

Test Plan:
- Reset (WIDTH=4): load q=1010 in D mode, then assert rst low between edges → q=0000, t_exc=0000 and sr_err=0 immediately, with no clock.
- D then T: mode=D, a=0110 → q=0110, t_exc=0110. Then mode=T, a=0011 → q=0101, t_exc=0011. Then en=0 → q=0101, t_exc=0000.
- JK, all four combos on one edge: q=0011, a(J)=0101, b(K)=0011 → bit0 toggles 1→0, bit1 clears 1→0, bit2 sets 0→1, bit3 holds 0. Result q=0100, t_exc=0111.
- SR illegal: q=1100, a=1010, b=0110 → bit3 holds 1, bit2 R clears 1→0, bit1 S=R=1 so it holds 0 and sr_err=1, bit0 holds 0. Result q=1000. sr_err stays 1 over 3 idle cycles, clears on clr_err; with clr_err and another illegal edge together → sr_err=1.
- Counter wrap: CNT_UP from q=1110 → tc=0, next edge q=1111 and tc=1, next edge q=0000 and t_exc=1111. Then CNT_DN from 0000 → tc=1, next edge q=1111.
- Reserved/mid-op: mode=6 with a=1111 → q unchanged. Counting up from 0 for 5 edges gives q=0101; pulse rst low → q=0000, and counting resumes 0001 after release.
